ps2_rx: RTL
===========

# ps2_rx

PS/2 keyboard frame receiver: the producer side of the `kb_hit`/`kb_data` interface consumed by the port controller.
- Samples the raw PS/2 clock/data lines in the 50 MHz domain, deglitches the clock and deserializes 11-bit device-to-host frames.
- Checks parity and stop bit; emits one-cycle `kb_hit` strobes with the received byte.
- Passes every byte unchanged (make codes, `F0` break prefix, `E0` extended prefix); prefix interpretation stays with the consumer.

## Interface
- `FILTER_LEN`, 8: consecutive identical samples required before the filtered PS/2 clock changes level.
- `TIMEOUT`, 100000: clock cycles (2 ms at 50 MHz) allowed between falling edges inside a frame before the frame is abandoned.
- `clock_50`  in  1  system clock, 50 MHz; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous, idle high.
- `ps2_dat`  in  1  raw PS/2 data line, asynchronous, idle high.
- `kb_hit`  out  1  one-cycle strobe: valid frame received.
- `kb_data`  out  8  last valid byte; held until the next valid frame.
- `kb_error`  out  1  one-cycle strobe: parity, stop or timeout error.

## Operation
- Input conditioning:
  - Both lines pass a 2-FF synchronizer.
  - Synchronized clock feeds a `FILTER_LEN`-bit shift register; filtered clock goes 1 when the register is all ones and 0 when all zeros, otherwise it holds.
  - Data is taken from the synchronizer output, not filtered.
- `fall` is a one-cycle pulse when the filtered clock goes 1→0. All frame sampling happens only on `fall`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), clear the shift register and `bit_cnt`, go to DATA. On `fall` with data=1, stay IDLE and raise no error.
  - DATA: on `fall`, shift data into bit 7 with right shift, so the LSB arrives first. After the 8th bit (`bit_cnt`=7), go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, go to IDLE. Frame is valid when stop=1 and XOR(data[7:0], parity)=1 (odd parity). If valid, load `kb_data` and pulse `kb_hit`; otherwise pulse `kb_error` and leave `kb_data` unchanged.
- Timeout:
  - Counter clears on every `fall` and while in IDLE; increments otherwise.
  - On reaching `TIMEOUT-1` outside IDLE: go to IDLE and pulse `kb_error`.
  - Timeout wins over a `fall` in the same cycle.
- No flow control: a new frame overwrites `kb_data`. The consumer must latch it on `kb_hit`.
- Reset (asynchronous, any state): FSM → IDLE, all counters 0, filter register and synchronizers all ones, filtered clock 1, `kb_hit`=0, `kb_error`=0, `kb_data`=8'h00.

## Timing
- Latency from a raw `ps2_clk` falling edge to `fall`: 2 synchronizer cycles + `FILTER_LEN` cycles = 10 cycles at defaults.
- Data is sampled from the synchronizer in the same cycle as `fall`. The PS/2 data setup (≥5 µs) far exceeds the filter delay, so sampling is stable.
- `kb_hit`/`kb_error` are registered and assert in the cycle after the `fall` that samples the stop bit.
- `kb_data` updates in the same cycle `kb_hit` asserts.
- `kb_hit` and `kb_error` are never high together and are never high for more than one consecutive cycle.
- Minimum spacing between strobes is one full frame (~660 µs at 16.7 kHz), so back-to-back strobes cannot occur.
- A clock glitch shorter than `FILTER_LEN` cycles produces no `fall`.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
  - Default `FILTER_LEN` and `TIMEOUT`.
- Sub-module `ps2_line_filter`: 2-FF synchronizer plus shift-register deglitch for one line. Outputs the filtered level, the `fall` pulse and the synchronized raw level. Instantiate once for `ps2_clk`; the data line uses only its synchronizer output.
- Top holds the FSM, shift register, `bit_cnt` (3 bits) and timeout counter (`$clog2(TIMEOUT)` bits).

## Test plan
- Valid frame 8'h1C (parity 0, odd total) at 12.5 kHz → one `kb_hit`, `kb_data`=8'h1C, `kb_error` stays 0.
- Sequence F0, 1C → two `kb_hit` pulses with `kb_data` 8'hF0 then 8'h1C; a third frame E0 overwrites to 8'hE0.
- Byte 8'h1C with parity=1 → `kb_error` pulse, no `kb_hit`, `kb_data` keeps the prior value. Stop bit=0 with a correct parity bit → same result.
- Frame stops after 4 data bits; idle 3 ms → `kb_error` pulse at `TIMEOUT` cycles after the last fall. Next valid frame 8'h5A → `kb_hit`, `kb_data`=8'h5A.
- 100 ns (5-cycle) low glitches injected on `ps2_clk` mid-bit in a valid 8'hA5 frame → no extra bits; `kb_data`=8'hA5.
- `reset_n` low for 3 cycles during DATA → outputs 0, `kb_data`=8'h00. Partial frame discarded with no strobe; following frame 8'h29 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and frame constants for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  localparam int DEF_FILTER_LEN = 8;
  localparam int DEF_TIMEOUT    = 100000;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchronizer plus shift-register deglitch for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic sync,
  output logic level,
  output logic fall
);

  logic                  meta;
  logic [FILTER_LEN-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      hist  <= '1;
      level <= 1'b1;
    end else begin
      meta <= raw;
      sync <= meta;
      hist <= {hist[FILTER_LEN-2:0], sync};
      if (&hist)
        level <= 1'b1;
      else if (~|hist)
        level <= 1'b0;
    end
  end

  // High for exactly the one cycle before level drops to 0.
  assign fall = level & ~|hist;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver producing kb_hit/kb_data strobes
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       kb_hit,
  output logic [7:0] kb_data,
  output logic       kb_error
);

  localparam int TW = $clog2(TIMEOUT);

  ps2_state_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d;
  logic [TW-1:0] tmo_q;
  logic        hit_d, err_d;
  logic        timeout;

  logic        fall;
  logic        dat_meta, dat_sync;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clock_50),
    .rst_n (reset_n),
    .raw   (ps2_clk),
    .sync  (),
    .level (),
    .fall  (fall)
  );

  // Data is only synchronized; it is sampled long after it settles.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  assign timeout = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    hit_d     = 1'b0;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (dat_sync == START_BIT) begin
            shift_d   = 8'h00;
            bit_cnt_d = 3'd0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1))
            state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_sync;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if ((dat_sync == STOP_BIT) && ((^shift_q) ^ par_q))
            hit_d = 1'b1;
          else
            err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      kb_hit    <= 1'b0;
      kb_error  <= 1'b0;
      kb_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      kb_hit    <= hit_d;
      kb_error  <= err_d;
      if (hit_d)
        kb_data <= shift_q;
      if (state_q == ST_IDLE || fall)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule
